// File: rtl/uio_arb_pkg.sv
// Shared types and default sizing for the uio bus arbiter.
package uio_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      TURN = 2'd2
   } arb_state_e;

   localparam int NREQ_DEF     = 2;
   localparam int TA_DEF       = 1;
   localparam int MAX_HOLD_DEF = 16;

endpackage

// File: rtl/uio_rr_picker.sv
// Combinational round-robin pick: the first requester found after last_owner,
// wrapping modulo NREQ, so the most recent owner has the lowest priority.
module uio_rr_picker
   import uio_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last_owner,
   output logic            valid,
   output logic [IW-1:0]   index
);

   logic [IW-1:0] cand;

   // Walk from the farthest candidate to the nearest; the nearest hit wins.
   always_comb begin
      valid = 1'b0;
      index = '0;
      cand  = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = IW'((int'(last_owner) + k) % NREQ);
         if (req[cand]) begin
            valid = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Arbiter for a shared bidirectional uio pad group. One requester owns the
// pads at a time; every hand-over passes through TA turnaround cycles with the
// pad drivers disabled.
// Optional feature: define UIO_ARB_TIMEOUT_EN to bound ownership to MAX_HOLD
// cycles while another requester is waiting (forced release pulses preempt).
//
// state | meaning
// IDLE  | no owner, waiting for ena and a request
// OWN   | owner_q holds the pads; gnt/uio_oe/uio_out follow its inputs
// TURN  | turnaround, pads released, turn_q counts down to the next pick
module uio_bus_arbiter
   import uio_arb_pkg::*;
#(
   parameter int NREQ     = NREQ_DEF,
   parameter int TA       = TA_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   dir,
   input  logic [NREQ*8-1:0] wdata,
   input  logic [7:0]        uio_in,
   output logic [NREQ-1:0]   gnt,
   output logic [7:0]        uio_out,
   output logic [7:0]        uio_oe,
   output logic [7:0]        rdata,
   output logic              rvalid,
   output logic              preempt
);

   localparam int            IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [IW-1:0] LAST_RST  = IW'(NREQ - 1);
   localparam logic [1:0]    TURN_INIT = 2'(TA - 1);

   arb_state_e    state_q, state_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [IW-1:0] last_q, last_d;
   logic [1:0]    turn_q, turn_d;
   logic [7:0]    rdata_q;
   logic          rvalid_q;
   logic          grant_try;
   logic          pick_valid;
   logic [IW-1:0] pick_idx;
   logic [NREQ-1:0] owner_oh;
   logic          owning;
   logic          owner_drives;
   logic          force_rel;

   uio_rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
      .req        (req),
      .last_owner (last_q),
      .valid      (pick_valid),
      .index      (pick_idx)
   );

   // One-hot view of the owner index.
   always_comb begin
      owner_oh           = '0;
      owner_oh[owner_q]  = 1'b1;
   end

   assign owning       = (state_q == OWN);
   assign owner_drives = owning && dir[owner_q];

`ifdef UIO_ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   logic [7:0] hold_q, hold_d;
   logic       preempt_q, preempt_d;

   assign force_rel = (hold_q == HOLD_MAX) && |(req & ~owner_oh);
   assign preempt_d = owning && req[owner_q] && force_rel;

   // Hold counter: 1 in the first OWN cycle, saturating at MAX_HOLD.
   always_comb begin
      hold_d = '0;
      if (state_d == OWN) begin
         if (state_q != OWN)
            hold_d = 8'd1;
         else if (hold_q != HOLD_MAX)
            hold_d = hold_q + 8'd1;
         else
            hold_d = hold_q;
      end
   end

   // Hold counter and preempt pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q    <= '0;
         preempt_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         preempt_q <= preempt_d;
      end
   end

   assign preempt = preempt_q;
`else
   assign force_rel = 1'b0;
   assign preempt   = 1'b0;
`endif

   // Next-state logic; a grant attempt happens from IDLE and at the end of TURN.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      turn_d    = turn_q;
      grant_try = 1'b0;
      case (state_q)
         IDLE: grant_try = 1'b1;
         OWN: begin
            if (!req[owner_q] || force_rel) begin
               state_d = TURN;
               turn_d  = TURN_INIT;
            end
         end
         TURN: begin
            if (turn_q == 2'd0)
               grant_try = 1'b1;
            else
               turn_d = turn_q - 2'd1;
         end
         default: state_d = IDLE;
      endcase
      if (grant_try) begin
         if (ena && pick_valid) begin
            state_d = OWN;
            owner_d = pick_idx;
            last_d  = pick_idx;
         end else begin
            state_d = IDLE;
         end
      end
   end

   // State, owner bookkeeping and the uio_in capture path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         last_q   <= LAST_RST;
         turn_q   <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         turn_q   <= turn_d;
         rdata_q  <= uio_in;
         rvalid_q <= owning && !dir[owner_q];
      end
   end

   assign gnt     = owning ? owner_oh : '0;
   assign uio_oe  = owner_drives ? 8'hFF : 8'h00;
   assign uio_out = owner_drives ? wdata[{owner_q, 3'b000} +: 8] : 8'h00;
   assign rdata   = rdata_q;
   assign rvalid  = rvalid_q;

endmodule
